adc_block_averager: RTL



---
 rtl/adc_pkg.sv | 21 ++
 rtl/adc_block_averager_if.sv | 28 ++
 rtl/adc_avg_outreg.sv | 84 ++++++++
 rtl/adc_block_averager.sv | 127 ++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC block averager.
// Holds ADC word-format constants, the output-register state type and the
// rounding-bias helper. Imported by the interface, top and output register.
package adc_pkg;

  localparam int ADC_DATA_W  = 24;
  localparam logic [ADC_DATA_W-1:0] ADC_FS_POS = 24'h7FFFFF;
  localparam logic [ADC_DATA_W-1:0] ADC_FS_NEG = 24'h800000;
  localparam int ADC_RAW_MSB = 31;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  // Half an LSB of the shifted result; zero in pass-through mode.
  function automatic int avg_bias(input int log2_avg);
    return (log2_avg == 0) ? 0 : (1 << (log2_avg - 1));
  endfunction

endpackage

// File: rtl/adc_block_averager_if.sv
// Result stream of the ADC block averager (valid/ready).
//   avg_data  : signed block average
//   avg_valid : result pending
//   avg_ready : consumer accepts when avg_valid && avg_ready
//   blk_min / blk_max : block min/max, present only with ADC_AVG_MINMAX_EN
// master = averager side, slave = consumer side.
interface adc_block_averager_if #(
  parameter int DATA_W = adc_pkg::ADC_DATA_W
) ();

  logic signed [DATA_W-1:0] avg_data;
  logic                     avg_valid;
  logic                     avg_ready;

`ifdef ADC_AVG_MINMAX_EN
  logic signed [DATA_W-1:0] blk_min;
  logic signed [DATA_W-1:0] blk_max;

  modport master (output avg_data, output avg_valid, output blk_min,
                  output blk_max, input avg_ready);
  modport slave  (input avg_data, input avg_valid, input blk_min,
                  input blk_max, output avg_ready);
`else
  modport master (output avg_data, output avg_valid, input avg_ready);
  modport slave  (input avg_data, input avg_valid, output avg_ready);
`endif

endinterface

// File: rtl/adc_avg_outreg.sv
// Output register of the ADC block averager: holds the latest block result,
// runs the valid/ready handshake and detects results lost to overrun.
// Optional macro ADC_AVG_MINMAX_EN adds the min/max result registers.
// Ports:
//   system_clock, reset_n : clock, synchronous active-low reset
//   load                  : a block completed this cycle
//   load_data             : rounded average of that block
//   load_min / load_max   : block min/max (ADC_AVG_MINMAX_EN only)
//   flag_clear            : clears overrun_flag (a same-cycle overrun wins)
//   overrun_flag          : sticky, a completed block replaced an unread one
//   avg                   : result stream (master side)
//
// state     | meaning
// ----------+----------------------------------------------
// OUT_EMPTY | no result pending, avg_valid = 0
// OUT_FULL  | result pending in avg_data, avg_valid = 1
module adc_avg_outreg
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic                     system_clock,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] load_data,
`ifdef ADC_AVG_MINMAX_EN
  input  logic signed [DATA_W-1:0] load_min,
  input  logic signed [DATA_W-1:0] load_max,
`endif
  input  logic                     flag_clear,
  output logic                     overrun_flag,
  adc_block_averager_if.master     avg
);

  out_state_t state;

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state         <= OUT_EMPTY;
      avg.avg_valid <= 1'b0;
      avg.avg_data  <= '0;
      overrun_flag  <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      avg.blk_min   <= '0;
      avg.blk_max   <= '0;
`endif
    end else begin
      // Clear first so a same-cycle overrun below takes priority.
      if (flag_clear) overrun_flag <= 1'b0;

      if (load) begin
        avg.avg_data <= load_data;
`ifdef ADC_AVG_MINMAX_EN
        avg.blk_min  <= load_min;
        avg.blk_max  <= load_max;
`endif
      end

      case (state)
        OUT_EMPTY: begin
          if (load) begin
            state         <= OUT_FULL;
            avg.avg_valid <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (load) begin
            // A handshake on the same edge consumes the old result, so
            // only an unread result counts as lost.
            if (!avg.avg_ready) overrun_flag <= 1'b1;
          end else if (avg.avg_ready) begin
            state         <= OUT_EMPTY;
            avg.avg_valid <= 1'b0;
          end
        end
        default: begin
          state         <= OUT_EMPTY;
          avg.avg_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/adc_block_averager.sv
// ADC block averager: takes the channel-0 raw word from the SPI master,
// extracts the signed conversion result, sums 2^LOG2_AVG samples and emits
// the rounded (half-up) block average on a valid/ready stream.
// Optional macro ADC_AVG_MINMAX_EN adds blk_min/blk_max on the stream.
// Ports:
//   system_clock, reset_n : clock, synchronous active-low reset
//   enable                : 1 = accumulate, 0 = keep the block cleared
//   raw_valid, raw_data   : one-cycle sample strobe and raw SPI word
//   flag_clear            : clears clip_flag and overrun_flag
//   clip_flag             : sticky, a full-scale sample was accepted
//   overrun_flag          : sticky, an unread result was overwritten
//   sample_count          : samples in the current block
//   avg                   : result stream (master side)
module adc_block_averager
  import adc_pkg::*;
#(
  parameter int LOG2_AVG = 4,
  parameter int DATA_W   = ADC_DATA_W
) (
  input  logic                system_clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                raw_valid,
  input  logic [31:0]         raw_data,
  input  logic                flag_clear,
  output logic                clip_flag,
  output logic                overrun_flag,
  output logic [LOG2_AVG:0]   sample_count,
  adc_block_averager_if.master avg
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(avg_bias(LOG2_AVG));
  // Full-scale codes scaled to the result width (top bits of the 24-bit codes).
  localparam logic [DATA_W-1:0] FS_POS = ADC_FS_POS[ADC_DATA_W-1 -: DATA_W];
  localparam logic [DATA_W-1:0] FS_NEG = ADC_FS_NEG[ADC_DATA_W-1 -: DATA_W];

  logic signed [DATA_W-1:0] sample;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [DATA_W-1:0] avg_next;
  logic [CNT_W-1:0]         count;
  logic                     accept;
  logic                     complete;
  logic                     clip_hit;
  logic                     unused_raw_lsbs;

  assign sample          = raw_data[ADC_RAW_MSB -: DATA_W];
  assign unused_raw_lsbs = ^raw_data[ADC_RAW_MSB-DATA_W:0];

  assign accept   = raw_valid && enable;
  assign complete = accept && (count == LAST_IDX);
  assign clip_hit = accept && ((sample == FS_POS) || (sample == FS_NEG));

  // The completing sample is folded in combinationally so the result is
  // registered on the same edge that clears the accumulator. The sum of
  // 2^LOG2_AVG in-range samples plus the bias cannot leave ACC_W bits, and
  // the shifted value always fits DATA_W.
  assign acc_sum  = acc + ACC_W'(sample);
  assign avg_next = DATA_W'((acc_sum + BIAS) >>> LOG2_AVG);

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      acc       <= '0;
      count     <= '0;
      clip_flag <= 1'b0;
    end else begin
      if (!enable) begin
        acc   <= '0;
        count <= '0;
      end else if (accept) begin
        if (complete) begin
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= acc_sum;
          count <= count + CNT_W'(1);
        end
      end

      if (clip_hit)        clip_flag <= 1'b1;
      else if (flag_clear) clip_flag <= 1'b0;
    end
  end

  assign sample_count = count;

`ifdef ADC_AVG_MINMAX_EN
  logic signed [DATA_W-1:0] run_min;
  logic signed [DATA_W-1:0] run_max;
  logic signed [DATA_W-1:0] min_next;
  logic signed [DATA_W-1:0] max_next;

  // The first sample of a block reinitialises both trackers.
  assign min_next = ((count == '0) || (sample < run_min)) ? sample : run_min;
  assign max_next = ((count == '0) || (sample > run_max)) ? sample : run_max;

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      run_min <= '0;
      run_max <= '0;
    end else if (accept) begin
      run_min <= min_next;
      run_max <= max_next;
    end
  end
`endif

  adc_avg_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .load         (complete),
    .load_data    (avg_next),
`ifdef ADC_AVG_MINMAX_EN
    .load_min     (min_next),
    .load_max     (max_next),
`endif
    .flag_clear   (flag_clear),
    .overrun_flag (overrun_flag),
    .avg          (avg)
  );

endmodule
